// File: rtl/mem_port_arbiter.sv
// Purpose: shares the one main-memory port between the I-side refill and D-side refill/writeback requesters.
// Latency: grant one cycle after the request is seen in IDLE; one word per mem_ack; done one cycle after the last ack.
// Backpressure: memory stalls the burst by withholding mem_ack; a losing requester waits for the next IDLE (no preemption).
module mem_port_arbiter #(
    parameter int LINE_ADDR_LEN = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_req,
    input  logic [31:0]              i_addr,
    output logic [31:0]              i_rdata,
    output logic                     i_rvalid,
    output logic                     i_done,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [31:0]              d_addr,
    input  logic [31:0]              d_wdata,
    output logic [LINE_ADDR_LEN-1:0] d_widx,
    output logic [31:0]              d_rdata,
    output logic                     d_rvalid,
    output logic                     d_done,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_ack,
    input  logic [31:0]              mem_rdata,
    output logic                     busy,
    output logic [1:0]               grant
);

    localparam int BASE_W = 32 - LINE_ADDR_LEN - 2;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_I_RD = 3'd1;
    localparam logic [2:0] S_D_RD = 3'd2;
    localparam logic [2:0] S_D_WR = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]               state_q, state_d;
    logic [LINE_ADDR_LEN-1:0] cnt_q, cnt_d;
    logic [BASE_W-1:0]        base_q, base_d;
    logic                     last_d_q, last_d_d;    // 1 = D side won the previous arbitration
    logic                     owner_d_q, owner_d_d;  // 1 = D side owns the current/finishing burst
    logic [31:0]              i_rdata_q, d_rdata_q;
    logic                     i_rvalid_q, d_rvalid_q;

    logic in_burst;
    logic last_word;
    logic unused_addr_bits;

    assign in_burst  = (state_q == S_I_RD) || (state_q == S_D_RD) || (state_q == S_D_WR);
    assign last_word = (cnt_q == {LINE_ADDR_LEN{1'b1}});

    // The word-offset bits of the requester addresses are deliberately dropped.
    assign unused_addr_bits = ^{i_addr[LINE_ADDR_LEN+1:0], d_addr[LINE_ADDR_LEN+1:0]};

    // Arbitration and burst sequencing: pick a winner in IDLE, step one word per ack, one DONE cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        last_d_d  = last_d_q;
        owner_d_d = owner_d_q;
        case (state_q)
            S_IDLE: begin
                // On a tie the side that did not win last time gets the port.
                if (i_req && (!d_req || last_d_q)) begin
                    state_d   = S_I_RD;
                    base_d    = i_addr[31:LINE_ADDR_LEN+2];
                    cnt_d     = '0;
                    owner_d_d = 1'b0;
                    last_d_d  = 1'b0;
                end else if (d_req) begin
                    state_d   = d_we ? S_D_WR : S_D_RD;
                    base_d    = d_addr[31:LINE_ADDR_LEN+2];
                    cnt_d     = '0;
                    owner_d_d = 1'b1;
                    last_d_d  = 1'b1;
                end
            end
            S_I_RD, S_D_RD, S_D_WR: begin
                if (mem_ack) begin
                    cnt_d = cnt_q + LINE_ADDR_LEN'(1);
                    if (last_word) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Requests are ignored here so the finishing requester can drop req first.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            base_q    <= '0;
            last_d_q  <= 1'b0;
            owner_d_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            base_q    <= base_d;
            last_d_q  <= last_d_d;
            owner_d_q <= owner_d_d;
        end
    end

    // Read return: capture the acked word for the owning side and pulse its rvalid for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            i_rvalid_q <= mem_ack && (state_q == S_I_RD);
            d_rvalid_q <= mem_ack && (state_q == S_D_RD);
            if (mem_ack && (state_q == S_I_RD)) begin
                i_rdata_q <= mem_rdata;
            end
            if (mem_ack && (state_q == S_D_RD)) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

    assign i_rdata   = i_rdata_q;
    assign i_rvalid  = i_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign i_done    = (state_q == S_DONE) && !owner_d_q;
    assign d_done    = (state_q == S_DONE) && owner_d_q;

    assign mem_req   = in_burst;
    assign mem_we    = (state_q == S_D_WR);
    assign mem_addr  = in_burst ? {base_q, cnt_q, 2'b00} : 32'h0;
    assign mem_wdata = (state_q == S_D_WR) ? d_wdata : 32'h0;
    assign d_widx    = (state_q == S_D_WR) ? cnt_q : '0;

    assign busy      = (state_q != S_IDLE);
    assign grant     = {(state_q == S_D_RD) || (state_q == S_D_WR), (state_q == S_I_RD)};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with LINE_ADDR_LEN = 3 (8-word bursts).
// Inputs change 1ns after the rising edge, outputs are checked on the falling edge.
// Each directed step is one cycle; cycle 0 of a scenario is the IDLE cycle where the request is first seen.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_rvalid;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_widx;
    logic [31:0] d_rdata;
    logic        d_rvalid;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;
    logic [1:0]  grant;

    int vecs = 0;
    int errs = 0;

    mem_port_arbiter #(.LINE_ADDR_LEN(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_rvalid  (i_rvalid),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_widx    (d_widx),
        .d_rdata   (d_rdata),
        .d_rvalid  (d_rvalid),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .grant     (grant)
    );

    // Requester writeback buffer: word k of the line holds 0x5500 + k.
    assign d_wdata = 32'h5500 + {29'd0, d_widx};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        i_req     = 1'b0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        i_addr    = 32'h0;
        d_addr    = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] ap;
        logic        ack_v;
        logic        burst_e;
        logic        rv_e;
        logic        done_e;
        int          nacks;
        int          rv_cnt;
        int          dd_cnt;
        int          drv_cnt;

        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_i_rvalid", {31'd0, i_rvalid}, 32'd0);
        chk("rst_d_done", {31'd0, d_done}, 32'd0);
        nxt();

        // 1: I-side line read, ack tied high
        for (int c = 0; c <= 10; c++) begin
            if (c == 0) begin
                i_req = 1'b1; i_addr = 32'h0000_1234; mem_ack = 1'b1;
            end
            if (c == 10) i_req = 1'b0;
            if (c >= 1 && c <= 8) mem_rdata = 32'hA0 + 32'(c - 1);
            @(negedge clk);
            if (c >= 1 && c <= 8) begin
                chk("t1_mem_req", {31'd0, mem_req}, 32'd1);
                chk("t1_mem_addr", mem_addr, 32'h1220 + 32'(4 * (c - 1)));
                chk("t1_grant", {30'd0, grant}, 32'd1);
            end
            if (c >= 2 && c <= 9) begin
                chk("t1_i_rvalid", {31'd0, i_rvalid}, 32'd1);
                chk("t1_i_rdata", i_rdata, 32'hA0 + 32'(c - 2));
            end
            if (c == 9) begin
                chk("t1_i_done", {31'd0, i_done}, 32'd1);
                chk("t1_mem_req_done", {31'd0, mem_req}, 32'd0);
            end
            if (c == 10) begin
                chk("t1_busy_after", {31'd0, busy}, 32'd0);
                chk("t1_i_rvalid_after", {31'd0, i_rvalid}, 32'd0);
            end
            nxt();
        end

        // 2: simultaneous requests after reset, then alternation
        do_reset();
        for (int c = 0; c <= 31; c++) begin
            if (c == 0) begin
                i_req = 1'b1; i_addr = 32'h0000_7000;
                d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000;
                mem_ack = 1'b1;
            end
            if (c == 10) d_req = 1'b0;
            if (c == 20) d_req = 1'b1;
            if (c == 30) begin
                i_req = 1'b0; d_req = 1'b0;
            end
            mem_rdata = 32'hD000 + 32'(c);
            @(negedge clk);
            if (c == 1) begin
                chk("t2_first_grant", {30'd0, grant}, 32'd2);
                chk("t2_d_addr0", mem_addr, 32'h2000);
            end
            if (c == 9) begin
                chk("t2_d_done", {31'd0, d_done}, 32'd1);
                chk("t2_i_done_quiet", {31'd0, i_done}, 32'd0);
                chk("t2_d_rdata_last", d_rdata, 32'hD008);
            end
            if (c == 10) chk("t2_idle_grant", {30'd0, grant}, 32'd0);
            if (c == 11) begin
                chk("t2_second_grant", {30'd0, grant}, 32'd1);
                chk("t2_i_addr0", mem_addr, 32'h7000);
            end
            if (c == 12) begin
                chk("t2_i_rvalid", {31'd0, i_rvalid}, 32'd1);
                chk("t2_i_rdata", i_rdata, 32'hD00B);
                chk("t2_d_rvalid_quiet", {31'd0, d_rvalid}, 32'd0);
            end
            if (c == 19) chk("t2_i_done", {31'd0, i_done}, 32'd1);
            if (c == 21) chk("t2_third_grant", {30'd0, grant}, 32'd2);
            if (c == 31) chk("t2_busy_end", {31'd0, busy}, 32'd0);
            nxt();
        end

        // 3: D-side writeback; address and we changes after grant are ignored
        dd_cnt = 0;
        drv_cnt = 0;
        for (int c = 0; c <= 10; c++) begin
            if (c == 0) begin
                d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8000_0040; mem_ack = 1'b1;
            end
            if (c == 2) begin
                d_addr = 32'hFFFF_FFC0; d_we = 1'b0;
            end
            if (c == 10) d_req = 1'b0;
            @(negedge clk);
            if (d_done) dd_cnt++;
            if (d_rvalid) drv_cnt++;
            if (c >= 1 && c <= 8) begin
                chk("t3_mem_we", {31'd0, mem_we}, 32'd1);
                chk("t3_mem_addr", mem_addr, 32'h8000_0040 + 32'(4 * (c - 1)));
                chk("t3_mem_wdata", mem_wdata, 32'h5500 + 32'(c - 1));
                chk("t3_d_widx", {29'd0, d_widx}, 32'(c - 1));
            end
            if (c == 9) begin
                chk("t3_mem_we_done", {31'd0, mem_we}, 32'd0);
                chk("t3_mem_wdata_done", mem_wdata, 32'h0);
            end
            nxt();
        end
        chk("t3_d_done_count", 32'(dd_cnt), 32'd1);
        chk("t3_d_rvalid_count", 32'(drv_cnt), 32'd0);

        // 4: I-side read with gapped acks
        ap = 16'b1001_0110_1011_0111;
        burst_e = 1'b0;
        rv_e = 1'b0;
        done_e = 1'b0;
        nacks = 0;
        rv_cnt = 0;
        for (int c = 0; c <= 17; c++) begin
            if (c == 0) begin
                i_req = 1'b1; i_addr = 32'h0000_3000;
            end
            if (c == 16) i_req = 1'b0;
            ack_v = (c >= 1 && c <= 16) ? ap[15 - (c - 1)] : 1'b0;
            mem_ack = ack_v;
            mem_rdata = 32'hC0 + 32'(nacks);
            @(negedge clk);
            if (i_rvalid) rv_cnt++;
            chk("t4_mem_req", {31'd0, mem_req}, {31'd0, burst_e});
            if (burst_e) chk("t4_mem_addr", mem_addr, 32'h3000 + 32'(4 * nacks));
            chk("t4_i_rvalid", {31'd0, i_rvalid}, {31'd0, rv_e});
            if (rv_e) chk("t4_i_rdata", i_rdata, 32'hC0 + 32'(nacks - 1));
            chk("t4_i_done", {31'd0, i_done}, {31'd0, done_e});
            rv_e = burst_e && ack_v;
            done_e = 1'b0;
            if (burst_e && ack_v) begin
                nacks++;
                if (nacks == 8) begin
                    burst_e = 1'b0;
                    done_e = 1'b1;
                end
            end
            if (c == 0) burst_e = 1'b1;
            nxt();
        end
        chk("t4_rvalid_count", 32'(rv_cnt), 32'd8);

        // 5: reset in cycle 4 of a D read, then a fresh I read
        mem_ack = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            if (c == 0) begin
                d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_4000;
            end
            if (c == 4) rst = 1'b1;
            if (c == 5) begin
                rst = 1'b0; d_req = 1'b0;
            end
            if (c == 6) begin
                i_req = 1'b1; i_addr = 32'h0000_5000;
            end
            @(negedge clk);
            if (c == 4) chk("t5_pre_mem_req", {31'd0, mem_req}, 32'd1);
            if (c == 5) begin
                chk("t5_busy", {31'd0, busy}, 32'd0);
                chk("t5_mem_req", {31'd0, mem_req}, 32'd0);
                chk("t5_grant", {30'd0, grant}, 32'd0);
                chk("t5_d_rvalid", {31'd0, d_rvalid}, 32'd0);
            end
            if (c >= 5) chk("t5_no_d_done", {31'd0, d_done}, 32'd0);
            if (c == 7) begin
                chk("t5_new_grant", {30'd0, grant}, 32'd1);
                chk("t5_new_addr", mem_addr, 32'h5000);
            end
            nxt();
        end

        // 6: request held through DONE is only re-granted from IDLE
        do_reset();
        for (int c = 0; c <= 11; c++) begin
            if (c == 0) begin
                i_req = 1'b1; i_addr = 32'h0000_6000; mem_ack = 1'b1;
            end
            @(negedge clk);
            if (c == 9) begin
                chk("t6_done_busy", {31'd0, busy}, 32'd1);
                chk("t6_done_grant", {30'd0, grant}, 32'd0);
                chk("t6_done_mem_req", {31'd0, mem_req}, 32'd0);
                chk("t6_done_i_done", {31'd0, i_done}, 32'd1);
            end
            if (c == 10) begin
                chk("t6_idle_busy", {31'd0, busy}, 32'd0);
                chk("t6_idle_mem_req", {31'd0, mem_req}, 32'd0);
            end
            if (c == 11) begin
                chk("t6_regrant", {30'd0, grant}, 32'd1);
                chk("t6_regrant_addr", mem_addr, 32'h6000);
            end
            nxt();
        end
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
